datapath_sequencer: RTL and testbench

Multi-cycle controller for the register-file/ALU Datapath block. It accepts one 32-bit RV32 instruction word at a time over a valid/ready handshake, decodes R-type ALU ops and BEQ/BNE, and drives the Datapath control pins (read_reg_num1, read_reg_num2, write_reg, alu_control, regwrite). For branches it samples zero_flag. It reports completion with a one-cycle done pulse plus status.

---
 rtl/datapath_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_datapath_sequencer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/datapath_sequencer.sv
// Purpose : multi-cycle controller that decodes one RV32 R-type/BEQ/BNE word and sequences the Datapath control pins.
// Latency : accept -> done = 3+SETTLE_CYCLES (R-type), 2+SETTLE_CYCLES (branch), 2 (illegal); all outputs registered.
// Backpr. : cmd_ready only in IDLE; with DATAPATH_SEQUENCER_PREFETCH_EN a one-entry buffer accepts while busy (cmd_ready = buffer empty).
//
// Ports:
//   clock, reset (async, active-low)
//   cmd_valid / cmd_ready / cmd_instr : instruction handshake
//   zero_flag                         : ALU zero result, sampled on the last EXEC edge of a branch
//   read_reg_num1/2, write_reg, alu_control, regwrite : Datapath control pins
//   done, branch_taken, illegal       : completion pulse and status (status valid while done=1)
// Optional feature macro: DATAPATH_SEQUENCER_PREFETCH_EN
module datapath_sequencer #(
    parameter int SETTLE_CYCLES = 1,
    parameter int ALU_CTRL_W    = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [31:0]           cmd_instr,
    input  logic                  zero_flag,
    output logic [4:0]            read_reg_num1,
    output logic [4:0]            read_reg_num2,
    output logic [4:0]            write_reg,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic                  regwrite,
    output logic                  done,
    output logic                  branch_taken,
    output logic                  illegal
);

    typedef enum logic [2:0] {S_IDLE, S_DECODE, S_EXEC, S_WB, S_RESP} state_t;
    typedef enum logic [1:0] {K_RTYPE, K_BEQ, K_BNE, K_ILL} kind_t;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // {funct7, funct3} keys for the supported R-type ops
    localparam logic [9:0] KEY_ADD = {7'b0000000, 3'b000};
    localparam logic [9:0] KEY_SUB = {7'b0100000, 3'b000};
    localparam logic [9:0] KEY_AND = {7'b0000000, 3'b111};
    localparam logic [9:0] KEY_OR  = {7'b0000000, 3'b110};
    localparam logic [9:0] KEY_SLT = {7'b0000000, 3'b010};

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    function automatic kind_t classify(input logic [31:0] w);
        kind_t k;
        k = K_ILL;
        if (w[6:0] == OP_RTYPE) begin
            case ({w[31:25], w[14:12]})
                KEY_ADD, KEY_SUB, KEY_AND, KEY_OR, KEY_SLT: k = K_RTYPE;
                default:                                    k = K_ILL;
            endcase
        end else if (w[6:0] == OP_BRANCH) begin
            if (w[14:12] == 3'b000)      k = K_BEQ;
            else if (w[14:12] == 3'b001) k = K_BNE;
        end
        return k;
    endfunction

    function automatic logic [3:0] alu_code(input logic [31:0] w);
        logic [3:0] a;
        a = 4'b0000;
        if (w[6:0] == OP_RTYPE) begin
            case ({w[31:25], w[14:12]})
                KEY_ADD: a = 4'b0010;
                KEY_SUB: a = 4'b0110;
                KEY_AND: a = 4'b0000;
                KEY_OR:  a = 4'b0001;
                KEY_SLT: a = 4'b0111;
                default: a = 4'b0000;
            endcase
        end else if (w[6:0] == OP_BRANCH && w[14:13] == 2'b00) begin
            // BEQ and BNE both subtract and look at the zero flag
            a = 4'b0110;
        end
        return a;
    endfunction

    state_t      state;
    kind_t       kind_q;
    logic [3:0]  cnt;

    logic        accept;
    logic        launch;      // start a new instruction into DECODE this edge
    logic [31:0] launch_word;
    logic        ready_nxt;

`ifdef DATAPATH_SEQUENCER_PREFETCH_EN
    logic        buf_vld;
    logic [31:0] buf_dat;
    logic        take_buf;
    logic        buf_load;
    logic        buf_vld_nxt;

    // RESP hands off straight to DECODE, either from the buffer or from a
    // command arriving on that very edge, so IDLE is skipped back-to-back.
    always_comb begin
        accept      = cmd_valid && cmd_ready;
        take_buf    = (state == S_RESP) && buf_vld;
        launch      = take_buf || (accept && (state == S_IDLE || state == S_RESP));
        launch_word = take_buf ? buf_dat : cmd_instr;
        buf_load    = accept && !(launch && !take_buf);
        buf_vld_nxt = buf_load ? 1'b1 : (take_buf ? 1'b0 : buf_vld);
        ready_nxt   = !buf_vld_nxt;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            buf_vld <= 1'b0;
            buf_dat <= 32'd0;
        end else begin
            buf_vld <= buf_vld_nxt;
            if (buf_load) buf_dat <= cmd_instr;
        end
    end
`else
    always_comb begin
        accept      = cmd_valid && cmd_ready;
        launch      = accept && (state == S_IDLE);
        launch_word = cmd_instr;
        // ready whenever the next state is IDLE; RESP always returns to IDLE here
        ready_nxt   = ((state == S_IDLE) && !launch) || (state == S_RESP);
    end
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= S_IDLE;
            kind_q        <= K_ILL;
            cnt           <= 4'd0;
            cmd_ready     <= 1'b0;
            read_reg_num1 <= 5'd0;
            read_reg_num2 <= 5'd0;
            write_reg     <= 5'd0;
            alu_control   <= '0;
            regwrite      <= 1'b0;
            done          <= 1'b0;
            branch_taken  <= 1'b0;
            illegal       <= 1'b0;
        end else begin
            done      <= 1'b0;
            regwrite  <= 1'b0;
            cmd_ready <= ready_nxt;

            if (launch) begin
                // Decode fields are driven from here on, visible during DECODE,
                // and hold until the next launch.
                state         <= S_DECODE;
                kind_q        <= classify(launch_word);
                read_reg_num1 <= launch_word[19:15];
                read_reg_num2 <= launch_word[24:20];
                write_reg     <= launch_word[11:7];
                alu_control   <= ALU_CTRL_W'(alu_code(launch_word));
                branch_taken  <= 1'b0;
                illegal       <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: state <= S_IDLE;
                    S_DECODE: begin
                        if (kind_q == K_ILL) begin
                            state   <= S_RESP;
                            done    <= 1'b1;
                            illegal <= 1'b1;
                        end else begin
                            state <= S_EXEC;
                            cnt   <= 4'd0;
                        end
                    end
                    S_EXEC: begin
                        if (cnt == SETTLE_LAST) begin
                            if (kind_q == K_RTYPE) begin
                                state    <= S_WB;
                                // x0 is hardwired: WB is still spent but nothing is written
                                regwrite <= (write_reg != 5'd0);
                            end else begin
                                state        <= S_RESP;
                                done         <= 1'b1;
                                branch_taken <= (kind_q == K_BNE) ? !zero_flag : zero_flag;
                            end
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end
                    S_WB: begin
                        state <= S_RESP;
                        done  <= 1'b1;
                    end
                    S_RESP:  state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_datapath_sequencer.sv
module tb_datapath_sequencer;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset;
    logic        cmd_valid [2];
    logic [31:0] cmd_instr [2];
    logic        zero_flag [2];
    logic        cmd_ready [2];
    logic [4:0]  rr1 [2];
    logic [4:0]  rr2 [2];
    logic [4:0]  wr [2];
    logic [3:0]  alu [2];
    logic        regwrite [2];
    logic        done [2];
    logic        btaken [2];
    logic        illegal [2];

    int checks = 0;
    int failures = 0;

    // unit 0: SETTLE_CYCLES=1, unit 1: SETTLE_CYCLES=3
    datapath_sequencer #(.SETTLE_CYCLES(1), .ALU_CTRL_W(4)) dut (
        .clock(clock), .reset(reset), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
        .cmd_instr(cmd_instr[0]), .zero_flag(zero_flag[0]), .read_reg_num1(rr1[0]),
        .read_reg_num2(rr2[0]), .write_reg(wr[0]), .alu_control(alu[0]), .regwrite(regwrite[0]),
        .done(done[0]), .branch_taken(btaken[0]), .illegal(illegal[0]));

    datapath_sequencer #(.SETTLE_CYCLES(3), .ALU_CTRL_W(4)) dut3 (
        .clock(clock), .reset(reset), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
        .cmd_instr(cmd_instr[1]), .zero_flag(zero_flag[1]), .read_reg_num1(rr1[1]),
        .read_reg_num2(rr2[1]), .write_reg(wr[1]), .alu_control(alu[1]), .regwrite(regwrite[1]),
        .done(done[1]), .branch_taken(btaken[1]), .illegal(illegal[1]));

    // Reference decode table for R-type: funct7, funct3, alu_control
    logic [6:0] r_f7  [5] = '{7'h00, 7'h20, 7'h00, 7'h00, 7'h00};
    logic [2:0] r_f3  [5] = '{3'd0, 3'd0, 3'd7, 3'd6, 3'd2};
    logic [3:0] r_alu [5] = '{4'h2, 4'h6, 4'h0, 4'h1, 4'h7};

    // kind: 0 = R-type, 1 = BEQ, 2 = BNE, 3 = illegal
    typedef struct packed {
        logic [1:0] kind;
        logic [3:0] alu;
    } exp_t;

    function automatic exp_t model(input logic [31:0] w);
        exp_t e;
        e.kind = 2'd3;
        e.alu  = 4'h0;
        if (w[6:0] == 7'h33) begin
            for (int i = 0; i < 5; i++)
                if (w[31:25] == r_f7[i] && w[14:12] == r_f3[i]) begin
                    e.kind = 2'd0;
                    e.alu  = r_alu[i];
                end
        end else if (w[6:0] == 7'h63 && (w[14:12] == 3'd0 || w[14:12] == 3'd1)) begin
            e.kind = (w[14:12] == 3'd0) ? 2'd1 : 2'd2;
            e.alu  = 4'h6;
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one instruction on unit u and check every cycle up to one past done.
    task automatic run_cmd(input int u, input logic [31:0] w, input logic zf, input string tag);
        exp_t e;
        int   settle;
        int   lat;
        int   waited;
        logic exp_bt;
        e      = model(w);
        settle = (u == 0) ? 1 : 3;
        lat    = (e.kind == 2'd3) ? 2 : ((e.kind == 2'd0) ? 3 + settle : 2 + settle);
        exp_bt = (e.kind == 2'd1) ? zf : ((e.kind == 2'd2) ? !zf : 1'b0);
        waited = 0;
        while (cmd_ready[u] !== 1'b1 && waited < 20) begin
            @(negedge clock);
            waited++;
        end
        chk({tag, "_ready"}, 32'(cmd_ready[u]), 32'd1);
        zero_flag[u] = ~zf;
        cmd_instr[u] = w;
        cmd_valid[u] = 1'b1;
        @(posedge clock);
        #1;
        cmd_valid[u] = 1'b0;
        cmd_instr[u] = $urandom;
        for (int c = 1; c <= lat + 1; c++) begin
            @(negedge clock);
            // only the value seen on the last EXEC edge may matter
            zero_flag[u] = (c == 1 + settle) ? zf : ~zf;
            if (c == 1) begin
                chk({tag, "_rs1"}, 32'(rr1[u]), 32'(w[19:15]));
                chk({tag, "_rs2"}, 32'(rr2[u]), 32'(w[24:20]));
                chk({tag, "_rd"}, 32'(wr[u]), 32'(w[11:7]));
                if (e.kind != 2'd3) chk({tag, "_alu"}, 32'(alu[u]), 32'(e.alu));
                chk({tag, "_btclr"}, 32'(btaken[u]), 32'd0);
                chk({tag, "_illclr"}, 32'(illegal[u]), 32'd0);
            end
            chk({tag, "_regwrite"}, 32'(regwrite[u]),
                32'(e.kind == 2'd0 && w[11:7] != 5'd0 && c == lat - 1));
            chk({tag, "_done"}, 32'(done[u]), 32'(c == lat));
            if (c >= lat) begin
                chk({tag, "_illegal"}, 32'(illegal[u]), 32'(e.kind == 2'd3));
                chk({tag, "_btaken"}, 32'(btaken[u]), 32'(exp_bt));
            end
        end
        chk({tag, "_ready_after"}, 32'(cmd_ready[u]), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        int          sel;
        logic [4:0]  rd;

        for (int u = 0; u < 2; u++) begin
            cmd_valid[u] = 1'b0;
            cmd_instr[u] = 32'd0;
            zero_flag[u] = 1'b0;
        end
        reset = 1'b1;
        #1 reset = 1'b0;
        #1;
        for (int u = 0; u < 2; u++)
            chk("reset_outs_async", {cmd_ready[u], rr1[u], rr2[u], wr[u], alu[u], regwrite[u],
                                     done[u], btaken[u], illegal[u]}, 32'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        for (int u = 0; u < 2; u++)
            chk("reset_outs_held", {cmd_ready[u], rr1[u], rr2[u], wr[u], alu[u], regwrite[u],
                                    done[u], btaken[u], illegal[u]}, 32'd0);
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("ready_after_release_u0", 32'(cmd_ready[0]), 32'd1);
        chk("ready_after_release_u1", 32'(cmd_ready[1]), 32'd1);
        @(negedge clock);

        // Directed steps
        run_cmd(0, 32'h002081B3, 1'b0, "add_x3");
        run_cmd(1, 32'h407302B3, 1'b0, "sub_x5_settle3");
        run_cmd(0, 32'h407302B3, 1'b1, "sub_x5");
        run_cmd(0, 32'h00208063, 1'b1, "beq_z1");
        run_cmd(0, 32'h00208063, 1'b0, "beq_z0");
        run_cmd(1, 32'h00209063, 1'b0, "bne_z0_settle3");
        run_cmd(1, 32'h00209063, 1'b1, "bne_z1_settle3");
        run_cmd(0, 32'h00208033, 1'b0, "add_x0");
        run_cmd(0, 32'h00000000, 1'b0, "illegal_zero");
        run_cmd(1, 32'h0020F1B3, 1'b0, "and_settle3");

        // Randomized mix against the reference model
        for (int n = 0; n < 24; n++) begin
            sel = $urandom_range(0, 9);
            rd  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            case (sel)
                0, 1, 2, 3, 4: w = {r_f7[sel], 5'($urandom), 5'($urandom), r_f3[sel], rd, 7'h33};
                5:       w = {7'($urandom), 5'($urandom), 5'($urandom), 3'd0, 5'($urandom), 7'h63};
                6:       w = {7'($urandom), 5'($urandom), 5'($urandom), 3'd1, 5'($urandom), 7'h63};
                7:       w = {7'h00, 5'($urandom), 5'($urandom), 3'd1, rd, 7'h33};
                8:       w = {7'($urandom), 5'($urandom), 5'($urandom), 3'd4, 5'($urandom), 7'h63};
                default: w = $urandom;
            endcase
            run_cmd(n % 2, w, 1'($urandom), "rand");
        end

        // Reset during WB of an ADD: regwrite drops at once, no done afterwards
        cmd_instr[0] = 32'h002081B3;
        cmd_valid[0] = 1'b1;
        @(posedge clock);
        #1 cmd_valid[0] = 1'b0;
        repeat (3) @(negedge clock);
        chk("wb_regwrite_before_reset", 32'(regwrite[0]), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("wb_reset_regwrite", 32'(regwrite[0]), 32'd0);
        chk("wb_reset_done", 32'(done[0]), 32'd0);
        chk("wb_reset_ready", 32'(cmd_ready[0]), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clock);
            chk("post_reset_done", 32'(done[0]), 32'd0);
            chk("post_reset_regwrite", 32'(regwrite[0]), 32'd0);
            chk("post_reset_ready", 32'(cmd_ready[0]), 32'd1);
        end

`ifdef DATAPATH_SEQUENCER_PREFETCH_EN
        // Back-to-back ADDs: the second sits in the buffer and enters DECODE
        // the cycle after the first done.
        cmd_instr[0] = 32'h002081B3;
        cmd_valid[0] = 1'b1;
        @(posedge clock);
        #1 cmd_instr[0] = 32'h00628233;
        @(negedge clock);
        chk("pf_ready_buffer_empty", 32'(cmd_ready[0]), 32'd1);
        @(posedge clock);
        #1 cmd_valid[0] = 1'b0;
        for (int c = 2; c <= 9; c++) begin
            @(negedge clock);
            if (c == 2) chk("pf_ready_buffer_full", 32'(cmd_ready[0]), 32'd0);
            chk("pf_done", 32'(done[0]), 32'(c == 4 || c == 8));
            chk("pf_regwrite", 32'(regwrite[0]), 32'(c == 3 || c == 7));
            if (c == 5) begin
                chk("pf_second_rd", 32'(wr[0]), 32'd4);
                chk("pf_second_rs1", 32'(rr1[0]), 32'd5);
                chk("pf_second_rs2", 32'(rr2[0]), 32'd6);
            end
        end
`else
        // cmd_valid held high while busy: only the first word is taken, the
        // second is accepted once IDLE returns (latency + 1 cadence).
        cmd_instr[0] = 32'h002081B3;
        cmd_valid[0] = 1'b1;
        @(posedge clock);
        #1 cmd_instr[0] = 32'h407302B3;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clock);
            if (c <= 5) chk("hold_rd_first", 32'(wr[0]), 32'd3);
            if (c <= 5) chk("hold_alu_first", 32'(alu[0]), 32'h2);
            chk("hold_done", 32'(done[0]), 32'(c == 4));
            chk("hold_ready", 32'(cmd_ready[0]), 32'(c == 5));
            if (c == 5) begin
                @(posedge clock);
                #1 cmd_valid[0] = 1'b0;
            end
            if (c == 6) begin
                chk("hold_rd_second", 32'(wr[0]), 32'd5);
                chk("hold_alu_second", 32'(alu[0]), 32'h6);
            end
        end
        repeat (5) @(negedge clock);
        chk("hold_back_idle", 32'(cmd_ready[0]), 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
